sseg_scan_ctrl: RTL and testbench



---
 rtl/sseg_pkg.sv | 30 +++
 rtl/sseg_slot_timer.sv | 32 +++
 rtl/sseg_scan_ctrl.sv | 78 +++++++
 tb/tb_sseg_scan_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment and anode values are active-low throughout.
package sseg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SSEG_OFF   = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic [2:0] BRIGHT_MAX = 3'd7;

  typedef logic [1:0] digit_t;

  // One complete frame: the unit that is double-buffered and committed atomically.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][7:0] pat;
    logic [NUM_DIGITS-1:0]      blank;
    logic [2:0]                 bright;
  } frame_t;

  localparam frame_t FRAME_RESET = '{
    pat:    {NUM_DIGITS{SSEG_OFF}},
    blank:  AN_OFF,
    bright: BRIGHT_MAX
  };

  // Active-low anode vector with only digit d enabled.
  function automatic logic [NUM_DIGITS-1:0] an_select(input digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Free-running slot counter and digit index for the display scan.
// frame_end marks the last cycle of the last digit slot.
module sseg_slot_timer
  import sseg_pkg::*;
#(
  parameter int SLOT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [SLOT_W-1:0] slot,
  output digit_t            digit,
  output logic              frame_end
);

  logic slot_wrap;

  assign slot_wrap = &slot;
  assign frame_end = slot_wrap && (digit == digit_t'(NUM_DIGITS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot  <= '0;
      digit <= '0;
    end else begin
      slot <= slot + 1'b1;
      if (slot_wrap) digit <= digit + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode display scanner with double-buffered frames,
// per-digit blanking, 8-level PWM brightness and an anti-ghost guard interval.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int SLOT_W = 16,
  parameter int GUARD  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] blank,
  input  logic [2:0] bright,
  input  logic       load,
  output logic       pending,
  output logic       frame_tick,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  logic [SLOT_W-1:0] slot;
  digit_t            digit;
  logic              frame_end;

  frame_t     shadow;
  frame_t     active;
  logic       lit;
  logic [3:0] an_nxt;
  logic [7:0] sseg_nxt;

  sseg_slot_timer #(
    .SLOT_W (SLOT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .slot      (slot),
    .digit     (digit),
    .frame_end (frame_end)
  );

  // The top three slot bits form an 8-step PWM ramp compared against brightness.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no latch is inferred.
    an_nxt   = AN_OFF;
    sseg_nxt = SSEG_OFF;
    lit      = (slot >= SLOT_W'(GUARD))
            && (slot[SLOT_W-1 -: 3] <= active.bright)
            && !active.blank[digit];
    if (lit) begin
      an_nxt   = an_select(digit);
      sseg_nxt = active.pat[digit];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: both frame buffers are reset because the display must come up dark.
      shadow     <= FRAME_RESET;
      active     <= FRAME_RESET;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= AN_OFF;
      sseg       <= SSEG_OFF;
    end else begin
      // Commit reads the pre-edge shadow, so a coincident load lands for the next frame.
      if (frame_end && pending) active <= shadow;
      if (load) shadow <= '{pat: {in3, in2, in1, in0}, blank: blank, bright: bright};
      pending    <= load || (pending && !frame_end);
      frame_tick <= frame_end;
      an         <= an_nxt;
      sseg       <= sseg_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed frame table, hand-written corner cases
// and random traffic, all checked against a cycle-count based reference model.
module tb_sseg_scan_ctrl;

  localparam int SLOT_W = 5;
  localparam int GUARD  = 4;
  localparam int SLOT   = 32;
  localparam int FRAME  = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0] blank = '0;
  logic [2:0] bright = '0;
  logic       load = 1'b0;
  logic       pending, frame_tick;
  logic [3:0] an;
  logic [7:0] sseg;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .SLOT_W (SLOT_W),
    .GUARD  (GUARD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .blank      (blank),
    .bright     (bright),
    .load       (load),
    .pending    (pending),
    .frame_tick (frame_tick),
    .an         (an),
    .sseg       (sseg)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_t counts clock edges since reset release; slot and digit
  // follow from plain division, and frames are whole 128-cycle periods.
  int unsigned m_t;
  logic [7:0]  m_act[4], m_sh[4];
  logic [3:0]  m_act_blank, m_sh_blank;
  logic [2:0]  m_act_bright, m_sh_bright;
  logic        m_pend, e_tick;
  logic [3:0]  e_an;
  logic [7:0]  e_sseg;
  int          lit_cnt[4];
  bit          counting = 1'b0;

  task automatic model_reset();
    m_t = 0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 8'hFF;
      m_sh[i]  = 8'hFF;
    end
    m_act_blank  = 4'hF;
    m_sh_blank   = 4'hF;
    m_act_bright = 3'd7;
    m_sh_bright  = 3'd7;
    m_pend       = 1'b0;
    e_tick       = 1'b0;
    e_an         = 4'hF;
    e_sseg       = 8'hFF;
  endtask

  task automatic model_step(input logic ld);
    int s, d;
    bit on, boundary;
    s  = int'(m_t % SLOT);
    d  = int'((m_t / SLOT) % 4);
    on = (s >= GUARD) && ((s / (SLOT / 8)) <= int'(m_act_bright)) && !m_act_blank[d];
    e_an   = 4'hF;
    e_sseg = 8'hFF;
    if (on) begin
      e_an[d] = 1'b0;
      e_sseg  = m_act[d];
    end
    boundary = (m_t % FRAME) == FRAME - 1;
    e_tick   = boundary;
    if (boundary && m_pend) begin
      m_act        = m_sh;
      m_act_blank  = m_sh_blank;
      m_act_bright = m_sh_bright;
      m_pend       = 1'b0;
    end
    if (ld) begin
      m_sh[0] = in0; m_sh[1] = in1; m_sh[2] = in2; m_sh[3] = in3;
      m_sh_blank  = blank;
      m_sh_bright = bright;
      m_pend      = 1'b1;
    end
    m_t++;
  endtask

  task automatic tick(input logic ld);
    @(negedge clk);
    load = ld;
    model_step(ld);
    @(posedge clk);
    #1;
    load = 1'b0;
    check("an", 32'(an), 32'(e_an));
    check("sseg", 32'(sseg), 32'(e_sseg));
    check("pending", 32'(pending), 32'(m_pend));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("one_anode", 32'($countones(~an) <= 1), 32'd1);
    if (counting)
      for (int i = 0; i < 4; i++)
        if (!an[i]) lit_cnt[i]++;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      tick(1'b0);
      n++;
    end while (!frame_tick && n < 3 * FRAME);
    check(name, 32'(frame_tick), 32'd1);
  endtask

  task automatic set_frame(input logic [31:0] p, input logic [3:0] bl, input logic [2:0] br);
    {in3, in2, in1, in0} = p;
    blank  = bl;
    bright = br;
  endtask

  typedef struct packed {
    logic [3:0][7:0] pats;
    logic [3:0]      blank;
    logic [2:0]      bright;
    logic [3:0][7:0] exp_lit;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Lit cycles per digit per slot: (bright+1)*4 - GUARD, or 0 when blanked.
    vecs[0] = '{pats: {8'hB0, 8'hA4, 8'hF9, 8'hC0}, blank: 4'b0000, bright: 3'd7, exp_lit: {8'd28, 8'd28, 8'd28, 8'd28}};
    vecs[1] = '{pats: {8'hB0, 8'hA4, 8'hF9, 8'hC0}, blank: 4'b0000, bright: 3'd0, exp_lit: {8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[2] = '{pats: {8'hB0, 8'hA4, 8'hF9, 8'hC0}, blank: 4'b0000, bright: 3'd3, exp_lit: {8'd12, 8'd12, 8'd12, 8'd12}};
    vecs[3] = '{pats: {8'hB0, 8'hA4, 8'hF9, 8'hC0}, blank: 4'b0101, bright: 3'd7, exp_lit: {8'd28, 8'd0, 8'd28, 8'd0}};
    vecs[4] = '{pats: {8'h8E, 8'h86, 8'hA1, 8'hC6}, blank: 4'b1000, bright: 3'd5, exp_lit: {8'd0, 8'd20, 8'd20, 8'd20}};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    #2 reset_n = 1'b1;

    // Nothing loaded yet: two dark frames with regular frame ticks.
    repeat (2 * FRAME) tick(1'b0);

    // Table: load mid-frame, wait for the commit, then count lit cycles over one frame.
    for (int v = 0; v < 5; v++) begin
      set_frame(vecs[v].pats, vecs[v].blank, vecs[v].bright);
      repeat (10) tick(1'b0);
      tick(1'b1);
      check($sformatf("v%0d_pending", v), 32'(pending), 32'd1);
      wait_tick($sformatf("v%0d_commit", v));
      check($sformatf("v%0d_pending_clr", v), 32'(pending), 32'd0);
      for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
      counting = 1'b1;
      repeat (FRAME) tick(1'b0);
      counting = 1'b0;
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_lit_d%0d", v, i), 32'(lit_cnt[i]), 32'(vecs[v].exp_lit[i]));
    end

    // Two loads in one frame, then a third exactly on the frame boundary.
    set_frame(32'h44332211, 4'b0000, 3'd7);
    tick(1'b1);
    repeat (7) tick(1'b0);
    set_frame(32'h88776655, 4'b0000, 3'd7);
    tick(1'b1);
    for (int n = 0; n < FRAME && (m_t % FRAME) != FRAME - 1; n++) tick(1'b0);
    set_frame(32'hCCBBAA99, 4'b0000, 3'd7);
    tick(1'b1);
    check("bnd_tick", 32'(frame_tick), 32'd1);
    check("bnd_pending", 32'(pending), 32'd1);
    repeat (5) tick(1'b0);
    check("bnd_b_an", 32'(an), 32'hE);
    check("bnd_b_sseg", 32'(sseg), 32'h55);
    wait_tick("bnd_next_commit");
    check("bnd_pending_clr", 32'(pending), 32'd0);
    repeat (5) tick(1'b0);
    check("bnd_c_sseg", 32'(sseg), 32'h99);

    // Asynchronous reset while digit 2 is lit.
    for (int n = 0; n < 2 * FRAME && (m_t % FRAME) != 80; n++) tick(1'b0);
    check("pre_rst_an", 32'(an), 32'hB);
    check("pre_rst_sseg", 32'(sseg), 32'hBB);
    #1 reset_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_sseg", 32'(sseg), 32'hFF);
    check("async_pending", 32'(pending), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    repeat (FRAME + 8) tick(1'b0);

    // Random traffic: inputs wiggle every cycle, loads are occasional.
    for (int n = 0; n < 12 * FRAME; n++) begin
      set_frame($urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      tick($urandom_range(0, 40) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
